clk_duty_gen: RTL and testbench

Synthesizable programmable clock/strobe generator. It derives a divided output waveform with independently programmable high and low phase lengths from the system clock, such as the 30 %/70 % duty pattern used by bench clock models. It sits directly upstream of the logic that consumes divided clocks and clock enables. It also provides edge strobes, so downstream logic can stay in the single `clock` domain.

---
 rtl/clk_duty_gen_if.sv | 24 ++
 rtl/clk_duty_gen.sv | 90 +++++++++
 tb/tb_clk_duty_gen.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/clk_duty_gen_if.sv
// clk_duty_gen_if: run/config controls and waveform/strobe outputs of the duty-cycle clock generator.
interface clk_duty_gen_if #(
   parameter int CNT_W  = 16,
   parameter int PCNT_W = 8
);
   logic              enable;
   logic              cfg_load;
   logic [CNT_W-1:0]  cfg_high;
   logic [CNT_W-1:0]  cfg_low;
   logic              clk_out;
   logic              rise_pulse;
   logic              fall_pulse;
   logic              cfg_ack;
   logic              running;
   logic [PCNT_W-1:0] period_cnt;
   modport master (
      output enable, cfg_load, cfg_high, cfg_low,
      input  clk_out, rise_pulse, fall_pulse, cfg_ack, running, period_cnt
   );
   modport slave (
      input  enable, cfg_load, cfg_high, cfg_low,
      output clk_out, rise_pulse, fall_pulse, cfg_ack, running, period_cnt
   );
endinterface

// File: rtl/clk_duty_gen.sv
// clk_duty_gen: programmable high/low phase clock generator with registered edge strobes and config handover.
module clk_duty_gen #(
   parameter int CNT_W    = 16,
   parameter int DEF_HIGH = 3,
   parameter int DEF_LOW  = 7,
   parameter int PCNT_W   = 8
) (
   input logic           clock,
   input logic           reset_n,
   clk_duty_gen_if.slave bus
);
   typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  act_high_q, act_high_d, act_low_q, act_low_d;
   logic [CNT_W-1:0]  pend_high_q, pend_high_d, pend_low_q, pend_low_d;
   logic              pend_valid_q, pend_valid_d;
   logic              clk_out_q, clk_out_d, rise_q, rise_d, fall_q, fall_d, ack_q, ack_d;
   logic [PCNT_W-1:0] pcnt_q, pcnt_d;
   logic              bnd, take_new;
   logic [CNT_W-1:0]  eff_high, eff_low;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         act_high_q   <= CNT_W'(DEF_HIGH);
         act_low_q    <= CNT_W'(DEF_LOW);
         pend_high_q  <= '0;
         pend_low_q   <= '0;
         pend_valid_q <= 1'b0;
         clk_out_q    <= 1'b0;
         rise_q       <= 1'b0;
         fall_q       <= 1'b0;
         ack_q        <= 1'b0;
         pcnt_q       <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         act_high_q   <= act_high_d;
         act_low_q    <= act_low_d;
         pend_high_q  <= pend_high_d;
         pend_low_q   <= pend_low_d;
         pend_valid_q <= pend_valid_d;
         clk_out_q    <= clk_out_d;
         rise_q       <= rise_d;
         fall_q       <= fall_d;
         ack_q        <= ack_d;
         pcnt_q       <= pcnt_d;
      end
   end

   // A load on the boundary cycle wins over both the pending and the active pair.
   always_comb begin
      take_new     = bus.cfg_load | pend_valid_q;
      eff_high     = bus.cfg_load ? bus.cfg_high : pend_valid_q ? pend_high_q : act_high_q;
      eff_low      = bus.cfg_load ? bus.cfg_low  : pend_valid_q ? pend_low_q  : act_low_q;
      bnd          = (state_q == IDLE) ? bus.enable :
                     (cnt_q == CNT_W'(1)) && (state_q == LOW || act_low_q == '0);
      pend_high_d  = bus.cfg_load ? bus.cfg_high : pend_high_q;
      pend_low_d   = bus.cfg_load ? bus.cfg_low  : pend_low_q;
      pend_valid_d = bnd ? 1'b0 : (pend_valid_q | bus.cfg_load);
      act_high_d   = bnd ? eff_high : act_high_q;
      act_low_d    = bnd ? eff_low  : act_low_q;
      state_d      = state_q;
      cnt_d        = (state_q == IDLE) ? cnt_q : cnt_q - CNT_W'(1);
      if (bnd) begin
         state_d = !bus.enable ? IDLE : (eff_high != '0) ? HIGH : (eff_low != '0) ? LOW : IDLE;
         cnt_d   = (eff_high != '0) ? eff_high : eff_low;
      end else if (state_q == HIGH && cnt_q == CNT_W'(1)) begin
         state_d = LOW;
         cnt_d   = act_low_q;
      end
   end

   always_comb begin
      clk_out_d = (state_d == HIGH);
      rise_d    = clk_out_d & ~clk_out_q;
      fall_d    = ~clk_out_d & clk_out_q;
      ack_d     = bnd & take_new;
      pcnt_d    = pcnt_q + PCNT_W'(rise_d);
   end

   assign bus.clk_out    = clk_out_q;
   assign bus.rise_pulse = rise_q;
   assign bus.fall_pulse = fall_q;
   assign bus.cfg_ack    = ack_q;
   assign bus.running    = (state_q != IDLE);
   assign bus.period_cnt = pcnt_q;
endmodule

// File: tb/tb_clk_duty_gen.sv
// tb_clk_duty_gen: vector table, directed corner sequences and random stimulus against a per-period waveform model.
module tb_clk_duty_gen;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   clk_duty_gen_if #(.CNT_W(16), .PCNT_W(8)) bus();
   clk_duty_gen #(.CNT_W(16), .DEF_HIGH(3), .DEF_LOW(7), .PCNT_W(8)) dut (
      .clock(clk), .reset_n(rst_n), .bus(bus)
   );

   typedef struct {
      bit en, ld; int h, l;
      bit c, r, f, a, run; int pc;
   } vec_t;
   vec_t tbl[$];

   int ntot = 0, npass = 0;
   int rises = 0, prev_pc = 0, highs = 0;
   bit wrapped = 0;

   // Model: at each period boundary the whole period is laid out as a list of per-cycle levels.
   bit m_run, m_clk, m_rise, m_fall, m_ack, m_pv;
   int m_ah, m_al, m_ph, m_pl, m_pc;
   bit m_q[$];

   task automatic chk(string nm, int act, int exp);
      ntot++;
      if (act == exp) npass++;
      else $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
   endtask

   task automatic mdl_reset();
      m_run = 0; m_clk = 0; m_rise = 0; m_fall = 0; m_ack = 0; m_pv = 0;
      m_ah = 3; m_al = 7; m_ph = 0; m_pl = 0; m_pc = 0;
      m_q.delete();
   endtask

   task automatic mdl_step(bit en, bit ld, int h, int l);
      bit bnd, nout;
      m_ack = 0;
      if (ld) begin m_ph = h; m_pl = l; m_pv = 1; end
      bnd = m_run ? (m_q.size() == 0) : en;
      if (bnd) begin
         if (m_pv) begin m_ah = m_ph; m_al = m_pl; m_pv = 0; m_ack = 1; end
         m_q.delete();
         m_run = en && (m_ah + m_al > 0);
         if (m_run) begin
            repeat (m_ah) m_q.push_back(1'b1);
            repeat (m_al) m_q.push_back(1'b0);
         end
      end
      nout   = m_run ? m_q.pop_front() : 1'b0;
      m_rise = nout & ~m_clk;
      m_fall = ~nout & m_clk;
      m_clk  = nout;
      if (m_rise) m_pc = (m_pc + 1) % 256;
   endtask

   task automatic step(bit en, bit ld, int h, int l);
      bus.enable = en; bus.cfg_load = ld; bus.cfg_high = 16'(h); bus.cfg_low = 16'(l);
      @(posedge clk);
      mdl_step(en, ld, h, l);
      @(negedge clk);
      chk("m_clk_out", int'(bus.clk_out), int'(m_clk));
      chk("m_rise", int'(bus.rise_pulse), int'(m_rise));
      chk("m_fall", int'(bus.fall_pulse), int'(m_fall));
      chk("m_ack", int'(bus.cfg_ack), int'(m_ack));
      chk("m_running", int'(bus.running), int'(m_run));
      chk("m_period_cnt", int'(bus.period_cnt), m_pc);
      if (bus.rise_pulse) begin
         rises++;
         if (prev_pc == 255) begin
            chk("pcnt_wrap", int'(bus.period_cnt), 0);
            wrapped = 1;
         end
      end
      if (bus.clk_out) highs++;
      prev_pc = int'(bus.period_cnt);
   endtask

   task automatic add(int n, bit en, bit ld, int h, int l, bit c, bit r, bit f, bit a, bit run, int pc);
      vec_t v;
      v = '{en, ld, h, l, c, r, f, a, run, pc};
      repeat (n) tbl.push_back(v);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.enable = 0; bus.cfg_load = 0; bus.cfg_high = '0; bus.cfg_low = '0;
      mdl_reset();
      // n, en, ld, h, l | clk, rise, fall, ack, run, pc
      add(1, 1, 0, 0, 0, 1, 1, 0, 0, 1, 1);
      add(2, 1, 0, 0, 0, 1, 0, 0, 0, 1, 1);
      add(1, 1, 0, 0, 0, 0, 0, 1, 0, 1, 1);
      add(6, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      add(1, 1, 0, 0, 0, 1, 1, 0, 0, 1, 2);
      add(1, 1, 1, 5, 5, 1, 0, 0, 0, 1, 2);
      add(1, 1, 0, 0, 0, 1, 0, 0, 0, 1, 2);
      add(1, 1, 0, 0, 0, 0, 0, 1, 0, 1, 2);
      add(6, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2);
      add(1, 1, 0, 0, 0, 1, 1, 0, 1, 1, 3);
      add(4, 1, 0, 0, 0, 1, 0, 0, 0, 1, 3);
      add(1, 1, 0, 0, 0, 0, 0, 1, 0, 1, 3);
      add(4, 1, 0, 0, 0, 0, 0, 0, 0, 1, 3);
      add(1, 1, 0, 0, 0, 1, 1, 0, 0, 1, 4);
      add(4, 0, 0, 0, 0, 1, 0, 0, 0, 1, 4);
      add(1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 4);
      add(4, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4);
      add(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4);
      add(1, 0, 1, 2, 2, 0, 0, 0, 0, 0, 4);
      add(1, 0, 1, 4, 1, 0, 0, 0, 0, 0, 4);
      add(1, 1, 0, 0, 0, 1, 1, 0, 1, 1, 5);
      add(3, 1, 0, 0, 0, 1, 0, 0, 0, 1, 5);
      add(1, 1, 0, 0, 0, 0, 0, 1, 0, 1, 5);
      add(1, 1, 0, 0, 0, 1, 1, 0, 0, 1, 6);
      add(1, 1, 1, 3, 7, 1, 0, 0, 0, 1, 6);
      add(2, 1, 0, 0, 0, 1, 0, 0, 0, 1, 6);
      add(1, 1, 0, 0, 0, 0, 0, 1, 0, 1, 6);
      add(1, 1, 0, 0, 0, 1, 1, 0, 1, 1, 7);
      add(2, 0, 0, 0, 0, 1, 0, 0, 0, 1, 7);
      add(1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 7);
      add(6, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7);
      add(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7);

      #1;
      chk("rst_clk_out", int'(bus.clk_out), 0);
      chk("rst_rise", int'(bus.rise_pulse), 0);
      chk("rst_fall", int'(bus.fall_pulse), 0);
      chk("rst_ack", int'(bus.cfg_ack), 0);
      chk("rst_running", int'(bus.running), 0);
      chk("rst_period_cnt", int'(bus.period_cnt), 0);
      @(negedge clk);
      rst_n = 1;

      foreach (tbl[i]) begin
         step(tbl[i].en, tbl[i].ld, tbl[i].h, tbl[i].l);
         chk($sformatf("tv%0d_clk_out", i), int'(bus.clk_out), int'(tbl[i].c));
         chk($sformatf("tv%0d_rise", i), int'(bus.rise_pulse), int'(tbl[i].r));
         chk($sformatf("tv%0d_fall", i), int'(bus.fall_pulse), int'(tbl[i].f));
         chk($sformatf("tv%0d_ack", i), int'(bus.cfg_ack), int'(tbl[i].a));
         chk($sformatf("tv%0d_running", i), int'(bus.running), int'(tbl[i].run));
         chk($sformatf("tv%0d_period_cnt", i), int'(bus.period_cnt), tbl[i].pc);
      end

      rises = 0;
      step(1, 1, 0, 4);
      repeat (11) step(1, 0, 0, 0);
      chk("h0_clk_out", int'(bus.clk_out), 0);
      chk("h0_running", int'(bus.running), 1);
      chk("h0_rises", rises, 0);
      rises = 0;
      step(1, 1, 2, 0);
      repeat (19) step(1, 0, 0, 0);
      chk("l0_clk_out", int'(bus.clk_out), 1);
      chk("l0_running", int'(bus.running), 1);
      chk("l0_rises", rises, 1);
      step(1, 1, 0, 0);
      repeat (9) step(1, 0, 0, 0);
      chk("z_clk_out", int'(bus.clk_out), 0);
      chk("z_running", int'(bus.running), 0);

      wrapped = 0;
      step(1, 1, 1, 1);
      repeat (600) step(1, 0, 0, 0);
      chk("wrap_seen", int'(wrapped), 1);

      step(1, 1, 3, 7);
      for (int i = 0; i < 30 && !(bus.rise_pulse && bus.cfg_ack); i++) step(1, 0, 0, 0);
      chk("ar_in_high", int'(bus.clk_out), 1);
      step(1, 0, 0, 0);
      #2 rst_n = 0;
      #1;
      chk("ar_clk_out", int'(bus.clk_out), 0);
      chk("ar_running", int'(bus.running), 0);
      chk("ar_period_cnt", int'(bus.period_cnt), 0);
      mdl_reset();
      @(negedge clk);
      rst_n = 1;
      highs = 0;
      step(1, 0, 0, 0);
      chk("ar_start_rise", int'(bus.rise_pulse), 1);
      repeat (9) step(1, 0, 0, 0);
      chk("ar_default_highs", highs, 3);
      step(1, 0, 0, 0);
      chk("ar_second_rise", int'(bus.rise_pulse), 1);

      for (int i = 0; i < 3000; i++)
         step($urandom_range(0, 15) != 0, $urandom_range(0, 11) == 0,
              $urandom_range(0, 5), $urandom_range(0, 5));

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end
endmodule
